// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for dmem_arbiter: one instance per requester.
// master = requester (LSU / loader), slave = arbiter.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        done;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  gnt, done
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output gnt, done
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter / sequencer for the single-port data BRAM.
// Optional: DMEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module dmem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     r0,
  dmem_arbiter_if.slave     r1,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RD
  } state_t;

  state_t     state;
  logic       ptr;
  logic       cur;
  logic       c_we;
  logic       c_uns;
  logic       c_mis;
  logic [1:0] c_size;
  logic [1:0] c_off;
  logic [1:0] gnt;
  logic [1:0] done;

  logic        win;
  logic        s_we;
  logic        s_uns;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        mis;
  logic [3:0]  mask;
  logic [31:0] wdat;
  logic [31:0] bsh;
  logic [31:0] hsh;
  logic [31:0] ext;

  // upper address bits wrap by design
  logic unused_addr;
  assign unused_addr = ^{r0.addr[31:ADDR_W+2],
                         r1.addr[31:ADDR_W+2]};

  assign r0.gnt  = gnt[0];
  assign r1.gnt  = gnt[1];
  assign r0.done = done[0];
  assign r1.done = done[1];

  // ptr only matters when both ask
  assign win = (r0.req & r1.req) ? ptr : r1.req;

  assign s_we    = win ? r1.we    : r0.we;
  assign s_uns   = win ? r1.uns   : r0.uns;
  assign s_size  = win ? r1.size  : r0.size;
  assign s_addr  = win ? r1.addr  : r0.addr;
  assign s_wdata = win ? r1.wdata : r0.wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    case (s_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = s_addr[0];
      default: mis = |s_addr[1:0];
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    mask = 4'b1111;
    wdat = s_wdata;
    case (s_size)
      2'b00: begin
        mask = 4'b0001 << s_addr[1:0];
        wdat = {4{s_wdata[7:0]}};
      end
      2'b01: begin
        mask = s_addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{s_wdata[15:0]}};
      end
      default: begin
        mask = 4'b1111;
        wdat = s_wdata;
      end
    endcase
  end

  assign bsh = ram_rdata >> {c_off, 3'b000};
  assign hsh = ram_rdata >> {c_off[1], 4'b0000};

  always_comb begin
    ext = ram_rdata;
    case (c_size)
      2'b00:   ext = {{24{~c_uns & bsh[7]}}, bsh[7:0]};
      2'b01:   ext = {{16{~c_uns & hsh[15]}}, hsh[15:0]};
      default: ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cur       <= 1'b0;
      c_we      <= 1'b0;
      c_uns     <= 1'b0;
      c_mis     <= 1'b0;
      c_size    <= 2'b00;
      c_off     <= 2'b00;
      gnt       <= 2'b00;
      done      <= 2'b00;
      rdata     <= '0;
      err       <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (r0.req | r1.req) begin
            cur       <= win;
            ptr       <= ~win;
            gnt       <= win ? 2'b10 : 2'b01;
            c_we      <= s_we;
            c_uns     <= s_uns;
            c_size    <= s_size;
            c_off     <= s_addr[1:0];
            c_mis     <= mis;
            ram_en    <= ~mis;
            ram_we    <= (s_we & ~mis) ? mask : 4'b0000;
            ram_addr  <= s_addr[ADDR_W+1:2];
            ram_wdata <= wdat;
            state     <= ACC;
          end
        end
        ACC: begin
          ram_en <= 1'b0;
          ram_we <= 4'b0000;
          if (c_we | c_mis) begin
            done  <= cur ? 2'b10 : 2'b01;
            err   <= c_mis;
            state <= IDLE;
          end else begin
            state <= RD;
          end
        end
        RD: begin
          rdata <= ext;
          done  <= cur ? 2'b10 : 2'b01;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane RAM model.
// Table vectors plus reset-in-RD and round-robin sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rdata;
  logic        err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [0:1023];

  int ncmp = 0;
  int nbad = 0;

  dmem_arbiter_if r0_if ();
  dmem_arbiter_if r1_if ();

  dmem_arbiter #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0        (r0_if),
    .r1        (r1_if),
    .rdata     (rdata),
    .err       (err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i])
          mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  x_we;
    logic [9:0]  x_addr;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
    bit          x_en;
    bit          x_err;
    int          x_lat;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(
    bit p, bit w, logic [1:0] sz, bit u,
    logic [31:0] a, logic [31:0] wd,
    logic [3:0] xwe, logic [9:0] xa,
    logic [31:0] xwd, logic [31:0] xrd,
    bit xen, bit xerr, int xlat
  );
    vec_t v;
    v.port = p;  v.we = w;  v.size = sz;
    v.uns = u;   v.addr = a; v.wdata = wd;
    v.x_we = xwe; v.x_addr = xa;
    v.x_wdata = xwd; v.x_rdata = xrd;
    v.x_en = xen; v.x_err = xerr; v.x_lat = xlat;
    return v;
  endfunction

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, required %h",
               name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    r0_if.req = 0; r0_if.we = 0; r0_if.size = 0;
    r0_if.uns = 0; r0_if.addr = 0; r0_if.wdata = 0;
    r1_if.req = 0; r1_if.we = 0; r1_if.size = 0;
    r1_if.uns = 0; r1_if.addr = 0; r1_if.wdata = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_gnt"},  32'({r1_if.gnt, r0_if.gnt}), 0);
    chk({tag, "_done"}, 32'({r1_if.done, r0_if.done}), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_err"},  32'(err), 0);
    chk({tag, "_en"},   32'(ram_en), 0);
    chk({tag, "_we"},   32'(ram_we), 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
  endtask

  task automatic run_vec(int k, vec_t v);
    logic [1:0] oh;
    bit got;
    int lat;
    oh = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    clear_reqs();
    if (v.port) begin
      r1_if.req = 1; r1_if.we = v.we; r1_if.size = v.size;
      r1_if.uns = v.uns; r1_if.addr = v.addr;
      r1_if.wdata = v.wdata;
    end else begin
      r0_if.req = 1; r0_if.we = v.we; r0_if.size = v.size;
      r0_if.uns = v.uns; r0_if.addr = v.addr;
      r0_if.wdata = v.wdata;
    end
    @(negedge clk);
    chk($sformatf("v%0d_gnt", k),
        32'({r1_if.gnt, r0_if.gnt}), 32'(oh));
    chk($sformatf("v%0d_en", k), 32'(ram_en), 32'(v.x_en));
    chk($sformatf("v%0d_we", k), 32'(ram_we), 32'(v.x_we));
    chk($sformatf("v%0d_addr", k),
        32'(ram_addr), 32'(v.x_addr));
    if (v.we)
      chk($sformatf("v%0d_wdata", k), ram_wdata, v.x_wdata);
    clear_reqs();
    got = 0;
    lat = 0;
    for (int n = 1; n <= 4 && !got; n++) begin
      @(negedge clk);
      if (r0_if.done | r1_if.done) begin
        got = 1;
        lat = n;
      end
    end
    if (!got) begin
      chk($sformatf("v%0d_done_timeout", k), 0, 1);
    end else begin
      chk($sformatf("v%0d_lat", k), lat, v.x_lat);
      chk($sformatf("v%0d_done", k),
          32'({r1_if.done, r0_if.done}), 32'(oh));
      chk($sformatf("v%0d_err", k), 32'(err), 32'(v.x_err));
      if (!v.we)
        chk($sformatf("v%0d_rdata", k), rdata, v.x_rdata);
    end
  endtask

  initial begin
    int ng;
    int last;
    vt[0]  = mk(0, 1, 2, 0, 32'h10, 32'hDEADBEEF,
                4'b1111, 4, 32'hDEADBEEF, 0, 1, 0, 1);
    vt[1]  = mk(0, 0, 2, 0, 32'h10, 0,
                4'b0000, 4, 0, 32'hDEADBEEF, 1, 0, 2);
    vt[2]  = mk(0, 1, 0, 0, 32'h13, 32'h80,
                4'b1000, 4, 32'h80808080, 0, 1, 0, 1);
    vt[3]  = mk(0, 0, 0, 0, 32'h13, 0,
                4'b0000, 4, 0, 32'hFFFFFF80, 1, 0, 2);
    vt[4]  = mk(0, 0, 0, 1, 32'h13, 0,
                4'b0000, 4, 0, 32'h00000080, 1, 0, 2);
    vt[5]  = mk(0, 0, 2, 0, 32'h10, 0,
                4'b0000, 4, 0, 32'h80ADBEEF, 1, 0, 2);
    vt[6]  = mk(0, 1, 2, 0, 32'h20, 32'h11223344,
                4'b1111, 8, 32'h11223344, 0, 1, 0, 1);
    vt[7]  = mk(0, 1, 1, 0, 32'h22, 32'h8001,
                4'b1100, 8, 32'h80018001, 0, 1, 0, 1);
    vt[8]  = mk(0, 0, 1, 0, 32'h22, 0,
                4'b0000, 8, 0, 32'hFFFF8001, 1, 0, 2);
    vt[9]  = mk(0, 0, 2, 0, 32'h20, 0,
                4'b0000, 8, 0, 32'h80013344, 1, 0, 2);
    vt[10] = mk(0, 0, 1, 1, 32'h20, 0,
                4'b0000, 8, 0, 32'h00003344, 1, 0, 2);
    vt[11] = mk(1, 0, 0, 0, 32'h21, 0,
                4'b0000, 8, 0, 32'h00000033, 1, 0, 2);
`ifdef DMEM_MISALIGN_TRAP_EN
    vt[12] = mk(0, 0, 2, 0, 32'h11, 0,
                4'b0000, 4, 0, 32'h00000033, 0, 1, 1);
`else
    vt[12] = mk(0, 0, 2, 0, 32'h11, 0,
                4'b0000, 4, 0, 32'h80ADBEEF, 1, 0, 2);
`endif
    vt[13] = mk(0, 0, 3, 0, 32'h1010, 0,
                4'b0000, 4, 0, 32'h80ADBEEF, 1, 0, 2);

    clear_reqs();
    rst = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1;

    for (int k = 0; k < 14; k++)
      run_vec(k, vt[k]);

    // reset while a load sits in RD
    @(negedge clk);
    r0_if.req = 1; r0_if.we = 0; r0_if.size = 2;
    r0_if.addr = 32'h10;
    @(negedge clk);
    chk("rst_rd_gnt", 32'(r0_if.gnt), 1);
    clear_reqs();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_zero("rst_rd");
    rst = 1;

    // both requesters hold req: expect strict alternation
    r0_if.req = 1; r0_if.we = 1; r0_if.size = 2;
    r0_if.addr = 32'h40; r0_if.wdata = 32'hA0A0A0A0;
    r1_if.req = 1; r1_if.we = 1; r1_if.size = 2;
    r1_if.addr = 32'h44; r1_if.wdata = 32'hB1B1B1B1;
    ng = 0;
    last = -1;
    for (int c = 0; c < 30 && ng < 6; c++) begin
      @(negedge clk);
      if (r0_if.done | r1_if.done)
        chk("rr_done", 32'({r1_if.done, r0_if.done}),
            (last == 1) ? 2 : 1);
      if (r0_if.gnt | r1_if.gnt) begin
        chk($sformatf("rr_gnt%0d", ng),
            32'({r1_if.gnt, r0_if.gnt}),
            (ng % 2 == 0) ? 1 : 2);
        last = r1_if.gnt ? 1 : 0;
        ng++;
      end
    end
    chk("rr_count", ng, 6);
    clear_reqs();
    @(negedge clk);
    chk("rr_last_done", 32'({r1_if.done, r0_if.done}),
        (last == 1) ? 2 : 1);
    repeat (2) @(negedge clk);
    chk("rr_mem0", mem[10'h10], 32'hA0A0A0A0);
    chk("rr_mem1", mem[10'h11], 32'hB1B1B1B1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
